// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between the fetch
// unit and mem_ctrl. Hits answer combinationally; misses refill one word.
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        flush,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic [31:0] fetch_inst,
   output logic        inst_IF_req,
   output logic [31:0] inst_IF_addr,
   input  logic        inst_IF_flag,
   input  logic [31:0] inst_IF
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MISS = 1'b1;

   logic [0:0]          state_reg;
   logic [0:0]          state_next;
   logic [31:0]         miss_addr_reg;
   logic [31:0]         miss_addr_next;
   logic                discard_reg;
   logic                discard_next;

   logic [LINES-1:0]    valid_vec;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   logic [INDEX_BITS-1:0] pc_idx;
   logic [TAG_BITS-1:0]   pc_tag;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_BITS-1:0]   miss_tag;
   logic                  hit;
   logic                  fwd_match;
   logic                  keep_fill;
   logic                  clear_all;
   logic                  fill_en;
   logic                  set_valid;
   logic                  unused_pc_bits;

   assign pc_idx         = fetch_pc[INDEX_BITS+1:2];
   assign pc_tag         = fetch_pc[31:INDEX_BITS+2];
   assign miss_idx       = miss_addr_reg[INDEX_BITS+1:2];
   assign miss_tag       = miss_addr_reg[31:INDEX_BITS+2];
   assign unused_pc_bits = ^fetch_pc[1:0];

   assign hit       = fetch_req && valid_vec[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign fwd_match = fetch_req && (fetch_pc[31:2] == miss_addr_reg[31:2]);
   // A flush arriving with the completing word must also keep the line invalid.
   assign keep_fill = !discard_reg && !flush;

   // The request stays asserted through the flag cycle; mem_ctrl ignores it then.
   assign inst_IF_req  = (state_reg == ST_MISS);
   assign inst_IF_addr = (state_reg == ST_MISS) ? miss_addr_reg : 32'h0;

   always_comb begin
      state_next     = state_reg;
      miss_addr_next = miss_addr_reg;
      discard_next   = discard_reg;
      clear_all      = 1'b0;
      fill_en        = 1'b0;
      set_valid      = 1'b0;
      fetch_valid    = 1'b0;
      fetch_inst     = 32'h0;
      case (state_reg)
         ST_IDLE: begin
            if (flush) begin
               clear_all = 1'b1;
            end
            if (hit && !flush) begin
               fetch_valid = 1'b1;
               fetch_inst  = data_mem[pc_idx];
            end
            if (fetch_req && (!hit || flush)) begin
               state_next     = ST_MISS;
               miss_addr_next = {fetch_pc[31:2], 2'b00};
               discard_next   = 1'b0;
            end
         end
         ST_MISS: begin
            if (flush) begin
               clear_all    = 1'b1;
               discard_next = 1'b1;
            end
            if (inst_IF_flag) begin
               fill_en      = 1'b1;
               set_valid    = keep_fill;
               state_next   = ST_IDLE;
               discard_next = 1'b0;
               if (rdy && fwd_match && keep_fill) begin
                  fetch_valid = 1'b1;
                  fetch_inst  = inst_IF;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         miss_addr_reg <= 32'h0;
         discard_reg   <= 1'b0;
      end else if (rdy) begin
         state_reg     <= state_next;
         miss_addr_reg <= miss_addr_next;
         discard_reg   <= discard_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_line
         logic line_valid_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               line_valid_reg <= 1'b0;
            end else if (rdy) begin
               if (clear_all) begin
                  line_valid_reg <= 1'b0;
               end else if (set_valid && (miss_idx == INDEX_BITS'(gi))) begin
                  line_valid_reg <= 1'b1;
               end
            end
         end
         assign valid_vec[gi] = line_valid_reg;
      end
   endgenerate

   // Tag and data need no reset: the valid bits qualify every read.
   always_ff @(posedge clk) begin
      if (rdy && fill_en) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= inst_IF;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: hits, conflict misses, redirects,
// delayed refills, flush and rdy/reset behaviour.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy;
   logic        flush;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic [31:0] fetch_inst;
   logic        inst_IF_req;
   logic [31:0] inst_IF_addr;
   logic        inst_IF_flag;
   logic [31:0] inst_IF;

   int n_cmp;
   int n_err;

   always #5 clk = ~clk;

   icache #(.INDEX_BITS(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rdy          (rdy),
      .flush        (flush),
      .fetch_req    (fetch_req),
      .fetch_pc     (fetch_pc),
      .fetch_valid  (fetch_valid),
      .fetch_inst   (fetch_inst),
      .inst_IF_req  (inst_IF_req),
      .inst_IF_addr (inst_IF_addr),
      .inst_IF_flag (inst_IF_flag),
      .inst_IF      (inst_IF)
   );

   // Inputs change 1ns after the rising edge; checks sample 2ns later.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_miss(input logic [31:0] pc);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      cycle();
      $display("txn: miss pc=%08h", pc);
   endtask

   task automatic to_flag(input int lat, input logic [31:0] data);
      repeat (lat - 1) cycle();
      inst_IF_flag = 1'b1;
      inst_IF      = data;
      #2;
   endtask

   task automatic end_flag();
      cycle();
      inst_IF_flag = 1'b0;
      inst_IF      = 32'h0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if (fetch_valid !== 1'b0 || fetch_inst !== 32'h0 || inst_IF_req !== 1'b0 || inst_IF_addr !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%b inst=%h req=%b addr=%h, expected all 0",
                  fetch_valid, fetch_inst, inst_IF_req, inst_IF_addr);
      end
      fetch_req = 1'b1;
      fetch_pc  = 32'h0;
      #1;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_no_hit: valid=%b, expected 0", fetch_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      fetch_req = 1'b0;
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b0 || fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL idle_no_req: req=%b valid=%b, expected 0/0", inst_IF_req, fetch_valid);
      end
      $display("txn: reset done");
   endtask

   task automatic test_miss_hit();
      fetch_req = 1'b1;
      fetch_pc  = 32'h0;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b0 || inst_IF_req !== 1'b0) begin
         n_err++;
         $display("FAIL t1_miss_cycle: valid=%b req=%b, expected 0/0", fetch_valid, inst_IF_req);
      end
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0) begin
         n_err++;
         $display("FAIL t1_req: req=%b addr=%h, expected 1/00000000", inst_IF_req, inst_IF_addr);
      end
      to_flag(4, 32'h0000_0013);
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'h0000_0013) begin
         n_err++;
         $display("FAIL t1_forward: valid=%b inst=%h, expected 1/00000013", fetch_valid, fetch_inst);
      end
      end_flag();
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'h0000_0013 || inst_IF_req !== 1'b0) begin
         n_err++;
         $display("FAIL t1_hit: valid=%b inst=%h req=%b, expected 1/00000013/0",
                  fetch_valid, fetch_inst, inst_IF_req);
      end
   endtask

   task automatic test_conflict();
      start_miss(32'h0000_0004);
      to_flag(4, 32'hAAAA_0004);
      end_flag();
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'hAAAA_0004) begin
         n_err++;
         $display("FAIL t2_hit_04: valid=%b inst=%h, expected 1/aaaa0004", fetch_valid, fetch_inst);
      end
      fetch_pc = 32'h0000_0104;
      #1;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t2_miss_104: valid=%b, expected 0", fetch_valid);
      end
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0104) begin
         n_err++;
         $display("FAIL t2_req_104: req=%b addr=%h, expected 1/00000104", inst_IF_req, inst_IF_addr);
      end
      to_flag(4, 32'hBBBB_0104);
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'hBBBB_0104) begin
         n_err++;
         $display("FAIL t2_fwd_104: valid=%b inst=%h, expected 1/bbbb0104", fetch_valid, fetch_inst);
      end
      end_flag();
      fetch_pc = 32'h0000_0004;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t2_evicted_04: valid=%b, expected 0", fetch_valid);
      end
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0004) begin
         n_err++;
         $display("FAIL t2_remiss_04: req=%b addr=%h, expected 1/00000004", inst_IF_req, inst_IF_addr);
      end
      to_flag(4, 32'hAAAA_0004);
      end_flag();
   endtask

   task automatic test_redirect();
      start_miss(32'h0000_0008);
      cycle();
      fetch_pc = 32'h0000_0040;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++;
         if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0008 || fetch_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t3_hold[%0d]: req=%b addr=%h valid=%b, expected 1/00000008/0",
                     i, inst_IF_req, inst_IF_addr, fetch_valid);
         end
         if (i < 2) cycle();
      end
      to_flag(1, 32'hCCCC_0008);
      n_cmp++;
      if (fetch_valid !== 1'b0 || inst_IF_addr !== 32'h0000_0008) begin
         n_err++;
         $display("FAIL t3_flag: valid=%b addr=%h, expected 0/00000008", fetch_valid, inst_IF_addr);
      end
      end_flag();
      fetch_pc = 32'h0000_0008;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'hCCCC_0008) begin
         n_err++;
         $display("FAIL t3_line2: valid=%b inst=%h, expected 1/cccc0008", fetch_valid, fetch_inst);
      end
      fetch_pc = 32'h0000_0040;
      #1;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t3_miss_40: valid=%b, expected 0", fetch_valid);
      end
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0040) begin
         n_err++;
         $display("FAIL t3_req_40: req=%b addr=%h, expected 1/00000040", inst_IF_req, inst_IF_addr);
      end
      to_flag(4, 32'h1111_0040);
      end_flag();
   endtask

   task automatic test_delay();
      start_miss(32'h0000_000C);
      for (int i = 1; i < 11; i++) begin
         #2;
         n_cmp++;
         if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_000C || fetch_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_stable[%0d]: req=%b addr=%h valid=%b, expected 1/0000000c/0",
                     i, inst_IF_req, inst_IF_addr, fetch_valid);
         end
         cycle();
      end
      inst_IF_flag = 1'b1;
      inst_IF      = 32'hDDDD_000C;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'hDDDD_000C) begin
         n_err++;
         $display("FAIL t4_fwd: valid=%b inst=%h, expected 1/dddd000c", fetch_valid, fetch_inst);
      end
      end_flag();
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'hDDDD_000C || inst_IF_req !== 1'b0) begin
         n_err++;
         $display("FAIL t4_hit: valid=%b inst=%h req=%b, expected 1/dddd000c/0",
                  fetch_valid, fetch_inst, inst_IF_req);
      end
   endtask

   task automatic test_flush();
      fetch_pc = 32'h0000_0000;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'h0000_0013) begin
         n_err++;
         $display("FAIL t5_pre_hit_00: valid=%b inst=%h, expected 1/00000013", fetch_valid, fetch_inst);
      end
      start_miss(32'h0000_0010);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      to_flag(3, 32'hEEEE_0010);
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t5_no_fwd: valid=%b, expected 0", fetch_valid);
      end
      end_flag();
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t5_line_invalid: valid=%b, expected 0", fetch_valid);
      end
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0010) begin
         n_err++;
         $display("FAIL t5_remiss_10: req=%b addr=%h, expected 1/00000010", inst_IF_req, inst_IF_addr);
      end
      to_flag(4, 32'hEEEE_0010);
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'hEEEE_0010) begin
         n_err++;
         $display("FAIL t5_refwd_10: valid=%b inst=%h, expected 1/eeee0010", fetch_valid, fetch_inst);
      end
      end_flag();
      fetch_pc = 32'h0000_0000;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t5_flushed_00: valid=%b, expected 0", fetch_valid);
      end
      cycle();
      to_flag(4, 32'h0000_0013);
      end_flag();
      // Flush while idle on a hitting pc: no hit that cycle, and the refill is kept.
      flush = 1'b1;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t5_idle_flush: valid=%b, expected 0", fetch_valid);
      end
      cycle();
      flush = 1'b0;
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0000) begin
         n_err++;
         $display("FAIL t5_flush_miss: req=%b addr=%h, expected 1/00000000", inst_IF_req, inst_IF_addr);
      end
      to_flag(4, 32'h0000_0013);
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'h0000_0013) begin
         n_err++;
         $display("FAIL t5_flush_fwd: valid=%b inst=%h, expected 1/00000013", fetch_valid, fetch_inst);
      end
      end_flag();
   endtask

   task automatic test_rdy_reset();
      start_miss(32'h0000_0014);
      rdy   = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++;
         if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0014) begin
            n_err++;
            $display("FAIL t6_frozen[%0d]: req=%b addr=%h, expected 1/00000014", i, inst_IF_req, inst_IF_addr);
         end
         cycle();
         flush = 1'b0;
      end
      rdy = 1'b1;
      to_flag(4, 32'h5555_0014);
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'h5555_0014) begin
         n_err++;
         $display("FAIL t6_fwd_14: valid=%b inst=%h, expected 1/55550014", fetch_valid, fetch_inst);
      end
      end_flag();
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_inst !== 32'h5555_0014) begin
         n_err++;
         $display("FAIL t6_hit_14: valid=%b inst=%h, expected 1/55550014", fetch_valid, fetch_inst);
      end
      fetch_pc = 32'h0000_0018;
      rdy      = 1'b0;
      repeat (2) cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b0) begin
         n_err++;
         $display("FAIL t6_idle_frozen: req=%b, expected 0", inst_IF_req);
      end
      rdy = 1'b1;
      cycle();
      #2;
      n_cmp++;
      if (inst_IF_req !== 1'b1 || inst_IF_addr !== 32'h0000_0018) begin
         n_err++;
         $display("FAIL t6_req_18: req=%b addr=%h, expected 1/00000018", inst_IF_req, inst_IF_addr);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (inst_IF_req !== 1'b0 || inst_IF_addr !== 32'h0 || fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t6_async_reset: req=%b addr=%h valid=%b, expected 0/00000000/0",
                  inst_IF_req, inst_IF_addr, fetch_valid);
      end
      cycle();
      rst_n    = 1'b1;
      fetch_pc = 32'h0000_0014;
      #2;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t6_inval_14: valid=%b, expected 0", fetch_valid);
      end
      fetch_pc = 32'h0000_0000;
      #1;
      n_cmp++;
      if (fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL t6_inval_00: valid=%b, expected 0", fetch_valid);
      end
      fetch_req = 1'b0;
      cycle();
   endtask

   initial begin
      rst_n        = 1'b0;
      rdy          = 1'b1;
      flush        = 1'b0;
      fetch_req    = 1'b0;
      fetch_pc     = 32'h0;
      inst_IF_flag = 1'b0;
      inst_IF      = 32'h0;
      n_cmp        = 0;
      n_err        = 0;
      test_reset();
      test_miss_hit();
      test_conflict();
      test_redirect();
      test_delay();
      test_flush();
      test_rdy_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
